sel_mux_pipe: RTL and testbench

- Parametrised, registered N-input, WIDTH-bit selector for the ProjectB datapath.
- Successor to the fixed 16-bit 8-to-1 combinational mux.
- Adds an output register with valid/ready handshake, a direct-select mode and an automatic round-robin scan mode that drains every valid channel once per request.
- Feeds the ALU/register-file write path, which applies back-pressure.

---
 rtl/sel_mux_pipe.sv | 175 +++++++++++++++++
 tb/tb_sel_mux_pipe.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sel_mux_pipe.sv
// -----------------------------------------------------------------------------
// sel_mux_pipe
//   Registered N-input, WIDTH-bit channel selector with a valid/ready output
//   stage. There are two ways to request a load:
//     * direct mode : load channel Sel into the output register.
//     * scan mode   : visit channels 0..N-1 in order and load each channel
//                     whose InValid bit is set. The walk stalls while the
//                     output slot is occupied.
//
// Optional build macro:
//   SEL_MUX_PARITY_EN - adds OutParity, the XOR reduction of the loaded data.
//                       It is registered alongside OutData and frozen with it.
//
// Ports:
//   Clk       in   rising-edge clock
//   Resetn    in   asynchronous active-low reset
//   InData    in   N*WIDTH flattened channels, channel k = InData[k*WIDTH +: WIDTH]
//   InValid   in   N per-channel valid mask, used only in scan mode
//   Sel       in   SELW channel index for direct mode
//   Mode      in   0 = direct, 1 = scan; sampled only when Start is accepted
//   Start     in   request, held by the requester until StartAck
//   StartAck  out  one-cycle pulse, asserted combinationally when Start is accepted
//   OutData   out  WIDTH registered selected data
//   OutChan   out  SELW channel index of OutData
//   OutValid  out  OutData/OutChan valid
//   OutReady  in   consumer accepts when OutValid && OutReady
//   OutParity out  XOR of OutData (present only with SEL_MUX_PARITY_EN)
//   Busy      out  scan in progress
// -----------------------------------------------------------------------------
module sel_mux_pipe #(
  parameter  int WIDTH = 16,
  parameter  int N     = 8,
  localparam int SELW  = $clog2(N)
) (
  input  logic                 Clk,
  input  logic                 Resetn,
  input  logic [N*WIDTH-1:0]   InData,
  input  logic [N-1:0]         InValid,
  input  logic [SELW-1:0]      Sel,
  input  logic                 Mode,
  input  logic                 Start,
  output logic                 StartAck,
  output logic [WIDTH-1:0]     OutData,
  output logic [SELW-1:0]      OutChan,
  output logic                 OutValid,
  input  logic                 OutReady,
`ifdef SEL_MUX_PARITY_EN
  output logic                 OutParity,
`endif
  output logic                 Busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } state_t;

  state_t             r_state;
  logic [SELW-1:0]    r_ptr;
  logic [WIDTH-1:0]   r_out_data;
  logic [SELW-1:0]    r_out_chan;
  logic               r_out_valid;
  logic               r_busy;
`ifdef SEL_MUX_PARITY_EN
  logic               r_out_parity;
`endif

  logic [WIDTH-1:0]   w_chan [N];
  logic               w_slot_free;
  logic               w_ptr_last;
  logic               w_ptr_valid;
  logic               w_direct_go;
  logic               w_scan_go;
  logic               w_scan_load;
  logic               w_scan_adv;
  logic               w_load;
  logic [SELW-1:0]    w_idx;
  logic [WIDTH-1:0]   w_load_data;

  // NOTE: every signal written here gets a value on every path (the defaults
  // come first), so no latch is inferred.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      w_chan[k] = InData[k*WIDTH +: WIDTH];
    end

    // The slot is free if it is empty or is being drained on this edge.
    w_slot_free = !r_out_valid || OutReady;
    w_ptr_last  = (r_ptr == SELW'(N - 1));
    w_ptr_valid = InValid[r_ptr];

    w_direct_go = (r_state == ST_IDLE) && Start && !Mode && w_slot_free;
    w_scan_go   = (r_state == ST_IDLE) && Start && Mode;

    // Scan: a valid channel waits for a free slot. An invalid channel is
    // skipped at once. InValid is sampled live every cycle.
    w_scan_load = (r_state == ST_SCAN) && w_ptr_valid && w_slot_free;
    w_scan_adv  = (r_state == ST_SCAN) && (!w_ptr_valid || w_slot_free);

    w_load      = w_direct_go || w_scan_load;
    w_idx       = (r_state == ST_SCAN) ? r_ptr : Sel;
    w_load_data = w_chan[w_idx];

    // StartAck is combinational, so it is gated with Resetn. This keeps it low
    // while reset is asserted, even though the FSM then reads as IDLE.
    StartAck    = Resetn && (w_direct_go || w_scan_go);
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // is read with its pre-edge value, so the order of the statements does not
  // matter.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_out_data   <= '0;
      r_out_chan   <= '0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
`ifdef SEL_MUX_PARITY_EN
      r_out_parity <= 1'b0;
`endif
    end else begin
      // Output stage: a load wins over a drain. Holding is implicit, so the
      // data stays frozen while OutValid && !OutReady.
      if (w_load) begin
        r_out_data   <= w_load_data;
        r_out_chan   <= w_idx;
        r_out_valid  <= 1'b1;
`ifdef SEL_MUX_PARITY_EN
        r_out_parity <= ^w_load_data;
`endif
      end else if (OutReady) begin
        r_out_valid  <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_scan_go) begin
            r_ptr   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (w_scan_adv) begin
            // The pointer saturates at N-1. Leaving channel N-1 ends the scan,
            // and Busy drops on the same edge.
            if (w_ptr_last) begin
              r_busy  <= 1'b0;
              r_state <= ST_DONE;
            end else begin
              r_ptr   <= r_ptr + 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign OutData   = r_out_data;
  assign OutChan   = r_out_chan;
  assign OutValid  = r_out_valid;
  assign Busy      = r_busy;
`ifdef SEL_MUX_PARITY_EN
  assign OutParity = r_out_parity;
`endif

endmodule

// File: tb/tb_sel_mux_pipe.sv
// -----------------------------------------------------------------------------
// tb_sel_mux_pipe
//   Self-checking bench for sel_mux_pipe with WIDTH=16 and N=8.
//   Scan results are compared with the expected transaction list, which is
//   the set InValid bits in ascending order together with their channel data.
//   Inputs are driven and outputs sampled just after the falling clock edge.
// -----------------------------------------------------------------------------
module tb_sel_mux_pipe;

  localparam int WIDTH = 16;
  localparam int N     = 8;
  localparam int SELW  = 3;

  logic                 Clk = 1'b0;
  logic                 Resetn;
  logic [N*WIDTH-1:0]   InData;
  logic [N-1:0]         InValid;
  logic [SELW-1:0]      Sel;
  logic                 Mode;
  logic                 Start;
  logic                 StartAck;
  logic [WIDTH-1:0]     OutData;
  logic [SELW-1:0]      OutChan;
  logic                 OutValid;
  logic                 OutReady;
  logic                 Busy;
`ifdef SEL_MUX_PARITY_EN
  logic                 OutParity;
`endif

  logic [WIDTH-1:0]     ch_val [N];

  int n_checks = 0;
  int n_fail   = 0;

  sel_mux_pipe #(.WIDTH(WIDTH), .N(N)) dut (
    .Clk      (Clk),
    .Resetn   (Resetn),
    .InData   (InData),
    .InValid  (InValid),
    .Sel      (Sel),
    .Mode     (Mode),
    .Start    (Start),
    .StartAck (StartAck),
    .OutData  (OutData),
    .OutChan  (OutChan),
    .OutValid (OutValid),
    .OutReady (OutReady),
`ifdef SEL_MUX_PARITY_EN
    .OutParity(OutParity),
`endif
    .Busy     (Busy)
  );

  always #5 Clk = ~Clk;

  always_comb begin
    for (int k = 0; k < N; k++) InData[k*WIDTH +: WIDTH] = ch_val[k];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_pattern();
    for (int k = 0; k < N; k++) ch_val[k] = WIDTH'(32'h1111 * k);
  endtask

  task automatic set_random_data();
    for (int k = 0; k < N; k++) ch_val[k] = WIDTH'($urandom);
  endtask

  // Direct-mode load with the consumer always ready. The load appears one
  // clock after acceptance and drains on the following edge.
  task automatic direct(input int sel, input string tag);
    @(negedge Clk);
    OutReady = 1'b1; Mode = 1'b0; Sel = SELW'(sel); Start = 1'b1;
    #1 check({tag, "_ack"}, 32'(StartAck), 32'd1);
    @(negedge Clk);
    Start = 1'b0;
    check({tag, "_data"},  32'(OutData),  32'(ch_val[sel]));
    check({tag, "_chan"},  32'(OutChan),  sel);
    check({tag, "_valid"}, 32'(OutValid), 32'd1);
    @(negedge Clk);
    check({tag, "_drain"}, 32'(OutValid), 32'd0);
  endtask

  // Scan request. ready_mode: 0 = always ready, 1 = ready low for 3 cycles
  // after the first item appears, 2 = random. exp_busy < 0 skips the Busy
  // cycle count.
  task automatic run_scan(input logic [N-1:0] mask, input int ready_mode,
                          input int exp_busy, input string tag);
    int               exp_q[$];
    int               got_chan[$];
    logic [WIDTH-1:0] got_data[$];
    int               busy_cnt   = 0;
    int               stall_left = 0;
    bit               seen_first = 0;
    bit               was_busy   = 0;
    bit               fell_seen  = 0;
    bit               done       = 0;
    bit               ready;

    for (int k = 0; k < N; k++) if (mask[k]) exp_q.push_back(k);

    @(negedge Clk);
    InValid = mask; Mode = 1'b1; OutReady = 1'b1; Start = 1'b1;
    #1 check({tag, "_ack"}, 32'(StartAck), 32'd1);

    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(negedge Clk);
      Start = 1'b0;
      if (Busy) begin
        busy_cnt++;
        was_busy = 1;
      end
      // Start must be ignored while a scan is running.
      if (cyc == 3 && Busy) begin
        Start = 1'b1; Mode = 1'b0;
        #1 check({tag, "_scan_noack"}, 32'(StartAck), 32'd0);
        Start = 1'b0; Mode = 1'b1;
      end
      // The first sample with Busy low after the scan is the DONE cycle, where
      // Start is also ignored.
      if (was_busy && !Busy && !fell_seen) begin
        fell_seen = 1;
        Start = 1'b1;
        #1 check({tag, "_done_noack"}, 32'(StartAck), 32'd0);
        Start = 1'b0;
      end

      if (ready_mode == 1 && OutValid && !seen_first) begin
        seen_first = 1;
        stall_left = 3;
      end
      if (ready_mode == 0)      ready = 1'b1;
      else if (ready_mode == 1) ready = (stall_left == 0);
      else                      ready = ($urandom_range(0, 3) != 0);
      if (ready_mode == 1 && stall_left > 0) stall_left--;

      OutReady = ready;
      if (OutValid && ready) begin
        got_chan.push_back(int'(OutChan));
        got_data.push_back(OutData);
      end
      if (was_busy && !Busy && !OutValid) done = 1;
    end
    check({tag, "_completed"}, 32'(done), 32'd1);

    @(negedge Clk);
    OutReady = 1'b1;

    check({tag, "_count"}, got_chan.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_chan.size(); i++) begin
      check($sformatf("%s_chan%0d", tag, i), got_chan[i], exp_q[i]);
      check($sformatf("%s_data%0d", tag, i), 32'(got_data[i]), 32'(ch_val[exp_q[i]]));
    end
    if (exp_busy >= 0) check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
  endtask

  initial begin
    Resetn = 1'b0; Start = 1'b0; Mode = 1'b0; Sel = '0;
    InValid = '0; OutReady = 1'b0;
    set_pattern();

    // Power-on reset values.
    #1;
    check("rst_data",  32'(OutData),  32'd0);
    check("rst_chan",  32'(OutChan),  32'd0);
    check("rst_valid", 32'(OutValid), 32'd0);
    check("rst_busy",  32'(Busy),     32'd0);
    check("rst_ack",   32'(StartAck), 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Resetn = 1'b1;

    // Direct select of channel 5.
    direct(5, "direct5");

    // Back-pressure: channel 2 is held, and the channel 3 request waits.
    @(negedge Clk);
    OutReady = 1'b0; Mode = 1'b0; Sel = 3'd2; Start = 1'b1;
    #1 check("bp_ack2", 32'(StartAck), 32'd1);
    @(negedge Clk);
    Sel = 3'd3;
    check("bp_data2",  32'(OutData),  32'h2222);
    check("bp_chan2",  32'(OutChan),  32'd2);
    check("bp_valid2", 32'(OutValid), 32'd1);
    #1 check("bp_noack3a", 32'(StartAck), 32'd0);
    @(negedge Clk);
    check("bp_frozen", 32'(OutData), 32'h2222);
    check("bp_held",   32'(OutValid), 32'd1);
    #1 check("bp_noack3b", 32'(StartAck), 32'd0);
    OutReady = 1'b1;
    #1 check("bp_ack3", 32'(StartAck), 32'd1);
    @(negedge Clk);
    Start = 1'b0;
    check("bp_data3",  32'(OutData),  32'h3333);
    check("bp_chan3",  32'(OutChan),  32'd3);
    check("bp_valid3", 32'(OutValid), 32'd1);
    @(negedge Clk);
    check("bp_drain3", 32'(OutValid), 32'd0);

    // Scan of a sparse mask, an empty mask, and a scan with a stall.
    run_scan(8'b1010_0101, 0, 8,  "scan_a5");
    run_scan(8'h00,        0, N,  "scan_empty");
    run_scan(8'hFF,        1, 11, "scan_stall");

    // Reset mid-scan while OutValid is high and the scan is stalled.
    @(negedge Clk);
    InValid = 8'hFF; OutReady = 1'b0; Mode = 1'b1; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    check("mid_valid_pre", 32'(OutValid), 32'd1);
    check("mid_busy_pre",  32'(Busy),     32'd1);
    #2 Resetn = 1'b0;
    Start = 1'b1;
    #1;
    check("mid_rst_data",  32'(OutData),  32'd0);
    check("mid_rst_chan",  32'(OutChan),  32'd0);
    check("mid_rst_valid", 32'(OutValid), 32'd0);
    check("mid_rst_busy",  32'(Busy),     32'd0);
    check("mid_rst_ack",   32'(StartAck), 32'd0);
    Start = 1'b0;
    @(negedge Clk);
    Resetn = 1'b1;
    run_scan(8'hFF, 0, 8, "rst_restart");

`ifdef SEL_MUX_PARITY_EN
    // Parity of a direct load: 16'h0007 has odd weight, 16'h0003 has even weight.
    ch_val[1] = 16'h0007;
    ch_val[2] = 16'h0003;
    @(negedge Clk);
    OutReady = 1'b1; Mode = 1'b0; Sel = 3'd1; Start = 1'b1;
    @(negedge Clk);
    Sel = 3'd2;
    check("parity_odd", 32'(OutParity), 32'd1);
    @(negedge Clk);
    Start = 1'b0;
    check("parity_even", 32'(OutParity), 32'd0);
    @(negedge Clk);
`endif

    // Randomized direct loads.
    for (int i = 0; i < 6; i++) begin
      set_random_data();
      direct($urandom_range(0, N - 1), $sformatf("rnd_direct%0d", i));
    end

    // Randomized scans with random back-pressure.
    for (int i = 0; i < 4; i++) begin
      set_random_data();
      run_scan(N'($urandom), 2, -1, $sformatf("rnd_scan%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
